// File: rtl/ntt_stream.sv
// ntt_stream: streaming Kyber-style NTT core.
// Coefficients are loaded serially into a register file. The core then runs the
// forward (Cooley-Tukey) or inverse (Gentleman-Sande plus scaling) transform in
// place, one butterfly per cycle, and streams the result out in index order.
// Barrett reduction is purely combinational, so it adds no pipeline latency.
// The registered output stage adds one cycle between the last butterfly (or
// scale step) and the first out_valid.
module ntt_stream #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329,
    parameter int ZETA  = 17,
    parameter int LOGN  = 8,
    parameter int NINV  = 3303
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_inv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int N    = 1 << LOGN;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOGN);

    localparam logic [LOGN-1:0]  ONE_N      = 1;
    localparam logic [LOGN-2:0]  ONE_H      = 1;
    localparam logic [LOGN-1:0]  IDX_LAST   = '1;
    localparam logic [LOGN-2:0]  BFLY_LAST  = '1;
    localparam logic [SW-1:0]    LAYER_LAST = SW'(LOGN - 2);
    localparam logic [SW-1:0]    LOGN_M1    = SW'(LOGN - 1);
    localparam logic [WIDTH-1:0] NINV_W     = WIDTH'(NINV);
    localparam logic [WIDTH:0]   Q_NARROW   = (WIDTH + 1)'(Q);
    localparam logic [2*WIDTH-1:0] Q_WIDE   = (2 * WIDTH)'(Q);
    localparam logic [2*WIDTH:0] BARRETT_FULL = {1'b1, {(2 * WIDTH){1'b0}}} / (2 * WIDTH + 1)'(Q);
    localparam logic [2*WIDTH-1:0] BARRETT_M  = BARRETT_FULL[2*WIDTH-1:0];

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_SCALE, S_OUT} state_e;

    // ZETA^brv(k) mod Q, brv reversing LOGN-1 bits; evaluated at elaboration.
    function automatic logic [WIDTH-1:0] zeta_of(input int k);
        int     rev;
        longint acc;
        rev = 0;
        for (int i = 0; i < LOGN - 1; i++)
            if (((k >> i) & 1) != 0) rev |= 1 << (LOGN - 2 - i);
        acc = 1;
        for (int i = 0; i < rev; i++) acc = (acc * ZETA) % Q;
        return WIDTH'(acc);
    endfunction

    // Barrett: the quotient estimate is at most one short, so one correction suffices.
    function automatic logic [WIDTH-1:0] reduce(input logic [2*WIDTH-1:0] x);
        logic [2*WIDTH-1:0] quot;
        logic [2*WIDTH-1:0] rem;
        quot = (2 * WIDTH)'(({{(2 * WIDTH){1'b0}}, x} * {{(2 * WIDTH){1'b0}}, BARRETT_M}) >> (2 * WIDTH));
        rem  = x - quot * Q_WIDE;
        if (rem >= Q_WIDE) rem = rem - Q_WIDE;
        return WIDTH'(rem);
    endfunction

    function automatic logic [WIDTH-1:0] add_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_NARROW) s = s - Q_NARROW;
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] sub_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + Q_NARROW;
        return WIDTH'(d);
    endfunction

    logic [WIDTH-1:0] zetas [HALF];
    for (genvar g = 0; g < HALF; g++) begin : g_zeta
        localparam logic [WIDTH-1:0] ZV = zeta_of(g);
        assign zetas[g] = ZV;
    end

    state_e           state_q;
    logic [LOGN-1:0]  idx_q;
    logic [SW-1:0]    layer_q;
    logic [LOGN-2:0]  bfly_q;
    logic             inv_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] rf [N];

    logic [SW-1:0]    shift_s;
    logic [LOGN-1:0]  lo_mask;
    logic [LOGN-1:0]  idx_a;
    logic [LOGN-1:0]  idx_b;
    logic [LOGN-2:0]  blk;
    logic [LOGN-2:0]  nblk;
    logic [LOGN-2:0]  tw_idx;
    logic [WIDTH-1:0] ra, rb, mul_a, mul_b, prod_red, bf_a, bf_b;

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_LOAD);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    // Butterfly addressing, twiddle selection and the shared modular datapath.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        shift_s  = '0;
        lo_mask  = '0;
        idx_a    = '0;
        idx_b    = '0;
        blk      = '0;
        nblk     = '0;
        tw_idx   = '0;
        mul_a    = '0;
        mul_b    = '0;
        // Pair distance is 2^shift_s; forward shrinks it each layer, inverse grows it.
        shift_s  = inv_q ? (layer_q + 1'b1) : (LOGN_M1 - layer_q);
        lo_mask  = (ONE_N << shift_s) - ONE_N;
        idx_a    = (({1'b0, bfly_q} & ~lo_mask) << 1) | ({1'b0, bfly_q} & lo_mask);
        idx_b    = idx_a | (ONE_N << shift_s);
        // A layer with nblk blocks uses twiddles nblk..2*nblk-1 (ascending fwd, descending inv).
        blk      = bfly_q >> shift_s;
        nblk     = ONE_H << (LOGN_M1 - shift_s);
        tw_idx   = inv_q ? ((nblk << 1) - ONE_H - blk) : (nblk + blk);
        ra       = rf[idx_a];
        rb       = rf[idx_b];
        if (state_q == S_SCALE) begin
            mul_a = NINV_W;
            mul_b = rf[idx_q];
        end else if (inv_q) begin
            mul_a = zetas[tw_idx];
            mul_b = sub_q(rb, ra);
        end else begin
            mul_a = zetas[tw_idx];
            mul_b = rb;
        end
        prod_red = reduce({{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b});
        bf_a     = inv_q ? add_q(ra, rb) : add_q(ra, prod_red);
        bf_b     = inv_q ? prod_red : sub_q(ra, prod_red);
    end

    // Control FSM: load counting, layer/butterfly sequencing and the output stage.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            layer_q     <= '0;
            bfly_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (idx_q == '0) inv_q <= mode_inv;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_COMPUTE;
                            layer_q <= '0;
                            bfly_q  <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    bfly_q <= bfly_q + 1'b1;
                    if (bfly_q == BFLY_LAST) begin
                        if (layer_q == LAYER_LAST) begin
                            layer_q <= '0;
                            state_q <= inv_q ? S_SCALE : S_OUT;
                        end else begin
                            layer_q <= layer_q + 1'b1;
                        end
                    end
                end
                S_SCALE: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_q <= S_OUT;
                end
                S_OUT: begin
                    if (out_valid_q && out_ready && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state_q     <= S_LOAD;
                    end else if (!out_valid_q || out_ready) begin
                        out_data_q  <= rf[idx_q];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (idx_q == IDX_LAST);
                        idx_q       <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Register file writes: load beats, both butterfly results, or one scaled value.
    always_ff @(posedge clk) begin
        // NOTE: the coefficient store has no reset; its contents are rewritten before use.
        case (state_q)
            S_LOAD: if (in_valid) rf[idx_q] <= in_data;
            S_COMPUTE: begin
                rf[idx_a] <= bf_a;
                rf[idx_b] <= bf_b;
            end
            S_SCALE: rf[idx_q] <= prod_red;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ntt_stream.sv
// tb_ntt_stream: randomized self-checking bench for ntt_stream against a
// loop-level NTT model, plus literal expectations for impulse/X/zero inputs.
module tb_ntt_stream;

    localparam int WIDTH = 16;
    localparam int Q     = 3329;
    localparam int ZETA  = 17;
    localparam int LOGN  = 8;
    localparam int NINV  = 3303;
    localparam int N     = 1 << LOGN;
    localparam int HALF  = N / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_inv;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    ntt_stream #(.WIDTH(WIDTH), .Q(Q), .ZETA(ZETA), .LOGN(LOGN), .NINV(NINV)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_inv  (mode_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int zt [HALF];
    int m [N];
    int in_vec [N];
    int exp_vec [N];
    int got [N];
    int orig [N];

    function automatic int powq(input int b, input int e);
        longint acc;
        acc = 1;
        for (int i = 0; i < e; i++) acc = (acc * b) % Q;
        return int'(acc);
    endfunction

    function automatic int brv(input int k);
        int r;
        r = 0;
        for (int i = 0; i < LOGN - 1; i++)
            if (((k >> i) & 1) != 0) r |= 1 << (LOGN - 2 - i);
        return r;
    endfunction

    function automatic int mulq(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % Q);
    endfunction

    task automatic model_fwd();
        int k;
        k = 1;
        for (int len = HALF; len >= 2; len = len / 2)
            for (int start = 0; start < N; start += 2 * len) begin
                int z;
                z = zt[k];
                k++;
                for (int j = start; j < start + len; j++) begin
                    int t;
                    t = mulq(z, m[j + len]);
                    m[j + len] = (m[j] - t + Q) % Q;
                    m[j] = (m[j] + t) % Q;
                end
            end
    endtask

    task automatic model_inv();
        int k;
        k = HALF - 1;
        for (int len = 2; len <= HALF; len = len * 2)
            for (int start = 0; start < N; start += 2 * len) begin
                int z;
                z = zt[k];
                k--;
                for (int j = start; j < start + len; j++) begin
                    int t;
                    t = m[j];
                    m[j] = (t + m[j + len]) % Q;
                    m[j + len] = mulq(z, (m[j + len] - t + Q) % Q);
                end
            end
        for (int i = 0; i < N; i++) m[i] = mulq(m[i], NINV);
    endtask

    // ---------------- output monitor / compare ----------------
    bit               mon_en = 1'b0;
    bit               bp_en  = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    int               out_count = 0;
    int               first_valid_cyc = -1;
    int               last_in_cyc = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                if (out_valid) check($sformatf("hold_data[%0d]", out_count), int'(out_data), int'(prev_data));
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (out_count < N) begin
                    check($sformatf("data[%0d]", out_count), int'(out_data), exp_vec[out_count]);
                    got[out_count] = int'(out_data);
                end else begin
                    check("extra_beat", out_count, N - 1);
                end
                check($sformatf("last[%0d]", out_count), int'(out_last), int'(out_count == N - 1));
                out_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic send_poly(input bit inv, input bit gaps);
        for (int i = 0; i < N; i++) begin
            int w;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(in_vec[i]);
            mode_inv = (i == 0) ? inv : 1'($urandom_range(0, 1));
            w = 0;
            while (!in_ready && w < 3000) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        last_in_cyc = cyc;
    endtask

    task automatic run_poly(input bit inv, input bit gaps, input bit bp, input string tag);
        int budget;
        int min_lat;
        min_lat         = inv ? (896 + 256) : 896;
        out_count       = 0;
        first_valid_cyc = -1;
        bp_en           = bp;
        mon_en          = 1'b1;
        send_poly(inv, gaps);
        budget = 6000;
        while (out_count < N && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({tag, " beats"}, out_count, N);
        check({tag, " latency_ok"},
              int'(first_valid_cyc >= 0 && (first_valid_cyc - last_in_cyc) >= min_lat), 1);
        check({tag, " valid_after"}, int'(out_valid), 0);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " ready_after"}, int'(in_ready), 1);
        mon_en = 1'b0;
        bp_en  = 1'b0;
    endtask

    task automatic set_impulse(input int pos);
        for (int i = 0; i < N; i++) in_vec[i] = (i == pos) ? 1 : 0;
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) in_vec[i] = int'($urandom_range(0, Q - 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        rst       = 1'b1;
        mode_inv  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < HALF; k++) zt[k] = powq(ZETA, brv(k));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_last", int'(out_last), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pin the model with hand-known values
        check("model zeta0", zt[0], 1);
        check("model zeta1", zt[1], 1729);
        check("model zeta2", zt[2], 2580);
        check("model zeta3", zt[3], 3289);
        check("model zeta_half_turn", powq(ZETA, HALF), Q - 1);
        for (int i = 0; i < N; i++) m[i] = (i == 0) ? 1 : 0;
        model_fwd();
        bad = 0;
        for (int i = 0; i < N; i++) if (m[i] != ((i % 2 == 0) ? 1 : 0)) bad++;
        check("model impulse mismatches", bad, 0);
        set_random();
        m = in_vec;
        model_fwd();
        model_inv();
        bad = 0;
        for (int i = 0; i < N; i++) if (m[i] != in_vec[i]) bad++;
        check("model roundtrip mismatches", bad, 0);

        // Impulse forward (literal expectation)
        set_impulse(0);
        for (int i = 0; i < N; i++) exp_vec[i] = (i % 2 == 0) ? 1 : 0;
        run_poly(1'b0, 1'b0, 1'b0, "impulse");

        // X forward (literal expectation)
        set_impulse(1);
        for (int i = 0; i < N; i++) exp_vec[i] = (i % 2 == 1) ? 1 : 0;
        run_poly(1'b0, 1'b0, 1'b0, "xpoly");

        // Random forward, then DUT output fed back through the inverse
        set_random();
        orig = in_vec;
        m = in_vec;
        model_fwd();
        exp_vec = m;
        run_poly(1'b0, 1'b0, 1'b0, "rand_fwd");
        in_vec  = got;
        exp_vec = orig;
        run_poly(1'b1, 1'b0, 1'b0, "roundtrip_inv");

        // Backpressure, then the same vector with input gaps
        set_random();
        m = in_vec;
        model_fwd();
        exp_vec = m;
        run_poly(1'b0, 1'b0, 1'b1, "backpressure");
        run_poly(1'b0, 1'b1, 1'b0, "gapped");

        // Zero vector in both modes
        for (int i = 0; i < N; i++) begin
            in_vec[i]  = 0;
            exp_vec[i] = 0;
        end
        run_poly(1'b0, 1'b0, 1'b0, "zero_fwd");
        run_poly(1'b1, 1'b0, 1'b0, "zero_inv");

        // Random inverse under gaps and backpressure
        set_random();
        m = in_vec;
        model_inv();
        exp_vec = m;
        run_poly(1'b1, 1'b1, 1'b1, "rand_inv");

        // Reset in the middle of COMPUTE, then a clean impulse run
        set_impulse(0);
        mon_en = 1'b0;
        send_poly(1'b0, 1'b0);
        repeat (400) @(posedge clk);
        #1;
        check("midrst busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst out_last", int'(out_last), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_vec[i] = (i % 2 == 0) ? 1 : 0;
        run_poly(1'b0, 1'b0, 1'b0, "post_reset_impulse");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
